imm_gen_stage: RTL and testbench

Parametrised, registered immediate generator for the decode stage. Given the raw immediate field of the current instruction and a select code, it produces the extended operand for ALU source B and holds it in a one-entry pipeline register with a valid/ready handshake toward execute. It adds a prefix mode that is new in this generation: a prefix instruction latches upper immediate bits, and the next immediate-producing instruction concatenates them, allowing full-width constants in two instructions. A decode flush input clears both the output register and any pending prefix.

---
 rtl/imm_gen_stage.sv | 133 +++++++++++++
 tb/tb_imm_gen_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Registered immediate generator for decode: extends the raw immediate field, supports a
// two-instruction prefix for full-width constants, and hands the result to execute via valid/ready.
module imm_gen_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXT_W-1:0] extend,
  input  logic [2:0]       imm_sel,
  input  logic [WIDTH-1:0] pc2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] immediate,
  output logic             prefix_pending
);

  localparam int unsigned PfxW = WIDTH - 8;

  localparam logic [2:0] SelSext5  = 3'b000;
  localparam logic [2:0] SelZext5  = 3'b001;
  localparam logic [2:0] SelSext8  = 3'b010;
  localparam logic [2:0] SelSext11 = 3'b011;
  localparam logic [2:0] SelPc2    = 3'b100;
  localparam logic [2:0] SelZext8  = 3'b101;
  localparam logic [2:0] SelPrefix = 3'b110;
  localparam logic [2:0] SelZero   = 3'b111;

  typedef enum logic [0:0] {StIdle, StPfx} state_e;

  state_e           state_q, state_d;
  logic [PfxW-1:0]  pfx_q, pfx_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] base;
  logic             accept;
  logic             is_prefix;
  logic             merge_pfx;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign is_prefix = (imm_sel == SelPrefix);

  always_comb begin
    base = '0;
    unique case (imm_sel)
      SelSext5:  base = {{(WIDTH-5){extend[4]}}, extend[4:0]};
      SelZext5:  base = {{(WIDTH-5){1'b0}}, extend[4:0]};
      SelSext8:  base = {{(WIDTH-8){extend[7]}}, extend[7:0]};
      SelSext11: base = {{(WIDTH-11){extend[10]}}, extend[10:0]};
      SelPc2:    base = pc2;
      SelZext8:  base = {{(WIDTH-8){1'b0}}, extend[7:0]};
      SelPrefix: base = '0;
      SelZero:   base = '0;
      default:   base = '0;
    endcase
  end

  // pc2 and zero ignore a pending prefix; every extension form takes its low byte under it.
  always_comb begin
    merge_pfx = 1'b0;
    if (state_q == StPfx) begin
      unique case (imm_sel)
        SelSext5, SelZext5, SelSext8, SelSext11, SelZext8: merge_pfx = 1'b1;
        default:                                            merge_pfx = 1'b0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = is_prefix ? StPfx : StIdle;
    end
  end

  // FSM: outputs
  always_comb begin
    prefix_pending = (state_q == StPfx);
  end

  always_comb begin
    pfx_d       = pfx_q;
    imm_d       = imm_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      pfx_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      if (is_prefix) begin
        pfx_d       = extend[PfxW-1:0];
        // An accepted prefix implies the old output was empty or consumed this cycle.
        out_valid_d = 1'b0;
      end else begin
        imm_d       = merge_pfx ? {pfx_q, base[7:0]} : base;
        out_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pfx_q       <= '0;
      imm_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pfx_q       <= pfx_d;
      imm_q       <= imm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign immediate = imm_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage: extension modes, prefix merge and discard,
// backpressure, flush and asynchronous reset.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] extend;
  logic [2:0]  imm_sel;
  logic [15:0] pc2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] immediate;
  logic        prefix_pending;

  int errors = 0;
  int checks = 0;

  imm_gen_stage #(
    .WIDTH(16),
    .EXT_W(11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .extend         (extend),
    .imm_sel        (imm_sel),
    .pc2            (pc2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .immediate      (immediate),
    .prefix_pending (prefix_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [10:0] e);
    in_valid = v;
    imm_sel  = s;
    extend   = e;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; pc2 = 16'h0000;
    drive(1'b0, 3'b000, 11'h000);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL reset_valid got=%0b want=0", out_valid); errors++; end
    checks++; if (immediate !== 16'h0000) begin
      $display("FAIL reset_imm got=%h want=0000", immediate); errors++; end
    checks++; if (prefix_pending !== 1'b0) begin
      $display("FAIL reset_pending got=%0b want=0", prefix_pending); errors++; end
    checks++; if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%0b want=1", in_ready); errors++; end
    rst = 1'b0;
    step();
  endtask

  task automatic test_extension();
    logic [2:0]  sels [5]  = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111};
    logic [10:0] exts [5]  = '{11'h016, 11'h016, 11'h400, 11'h0F0, 11'h3FF};
    logic [15:0] wants [5] = '{16'hFFF6, 16'h0016, 16'hFC00, 16'h00F0, 16'h0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sels[i], exts[i]);
      step();
      checks++; if (out_valid !== 1'b1 || immediate !== wants[i]) begin
        $display("FAIL ext_sel%0d got valid=%0b imm=%h want valid=1 imm=%h",
                 sels[i], out_valid, immediate, wants[i]); errors++; end
    end
    drive(1'b0, 3'b000, 11'h000);
    step();
    checks++; if (out_valid !== 1'b0) begin
      $display("FAIL ext_drain got=%0b want=0", out_valid); errors++; end
  endtask

  task automatic test_prefix();
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 11'h0AB);
    step();
    checks++; if (prefix_pending !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL pfx_latch got pend=%0b valid=%0b want pend=1 valid=0",
               prefix_pending, out_valid); errors++; end
    drive(1'b1, 3'b010, 11'h0CD);
    step();
    checks++; if (immediate !== 16'hABCD || out_valid !== 1'b1 || prefix_pending !== 1'b0) begin
      $display("FAIL pfx_merge got imm=%h valid=%0b pend=%0b want imm=abcd valid=1 pend=0",
               immediate, out_valid, prefix_pending); errors++; end
    drive(1'b1, 3'b110, 11'h012);
    step();
    drive(1'b1, 3'b110, 11'h034);
    step();
    checks++; if (prefix_pending !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL pfx_overwrite got pend=%0b valid=%0b want pend=1 valid=0",
               prefix_pending, out_valid); errors++; end
    drive(1'b1, 3'b001, 11'h005);
    step();
    checks++; if (immediate !== 16'h3405 || out_valid !== 1'b1) begin
      $display("FAIL pfx_merge2 got imm=%h valid=%0b want imm=3405 valid=1",
               immediate, out_valid); errors++; end
    drive(1'b0, 3'b000, 11'h000);
    step();
  endtask

  task automatic test_prefix_discard();
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 11'h0AB);
    step();
    pc2 = 16'h1234;
    drive(1'b1, 3'b100, 11'h0CD);
    step();
    checks++; if (immediate !== 16'h1234 || prefix_pending !== 1'b0) begin
      $display("FAIL discard_pc2 got imm=%h pend=%0b want imm=1234 pend=0",
               immediate, prefix_pending); errors++; end
    drive(1'b1, 3'b010, 11'h0CD);
    step();
    checks++; if (immediate !== 16'hFFCD) begin
      $display("FAIL discard_after got=%h want=ffcd", immediate); errors++; end
    drive(1'b0, 3'b000, 11'h000);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 11'h016);
    step();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 11'h016);
    #1;
    checks++; if (in_ready !== 1'b0) begin
      $display("FAIL bp_in_ready got=%0b want=0", in_ready); errors++; end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (immediate !== 16'hFFF6 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d got imm=%h valid=%0b rdy=%0b want imm=fff6 valid=1 rdy=0",
                 i, immediate, out_valid, in_ready); errors++; end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin
      $display("FAIL bp_release_rdy got=%0b want=1", in_ready); errors++; end
    step();
    checks++; if (immediate !== 16'h0016 || out_valid !== 1'b1) begin
      $display("FAIL bp_new got imm=%h valid=%0b want imm=0016 valid=1",
               immediate, out_valid); errors++; end
    drive(1'b0, 3'b000, 11'h000);
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 11'h0AB);
    step();
    flush = 1'b1;
    drive(1'b1, 3'b000, 11'h016);
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || prefix_pending !== 1'b0) begin
      $display("FAIL flush_pfx got valid=%0b pend=%0b want valid=0 pend=0",
               out_valid, prefix_pending); errors++; end
    drive(1'b1, 3'b010, 11'h0CD);
    step();
    checks++; if (immediate !== 16'hFFCD || out_valid !== 1'b1) begin
      $display("FAIL flush_after got imm=%h valid=%0b want imm=ffcd valid=1",
               immediate, out_valid); errors++; end
    // Flush against a stalled valid output: valid drops, value is frozen, input ignored.
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, 3'b001, 11'h016);
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || immediate !== 16'hFFCD) begin
      $display("FAIL flush_valid got valid=%0b imm=%h want valid=0 imm=ffcd",
               out_valid, immediate); errors++; end
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 11'h000);
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    pc2 = 16'h1234;
    drive(1'b1, 3'b100, 11'h000);
    step();
    drive(1'b0, 3'b000, 11'h000);
    checks++; if (immediate !== 16'h1234 || out_valid !== 1'b1) begin
      $display("FAIL rstmid_load got imm=%h valid=%0b want imm=1234 valid=1",
               immediate, out_valid); errors++; end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || immediate !== 16'h0000 || prefix_pending !== 1'b0) begin
      $display("FAIL rstmid_async got valid=%0b imm=%h pend=%0b want 0/0000/0",
               out_valid, immediate, prefix_pending); errors++; end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'b110, 11'h0AB);
    step();
    drive(1'b0, 3'b000, 11'h000);
    #2 rst = 1'b1;
    #1;
    checks++; if (prefix_pending !== 1'b0) begin
      $display("FAIL rstmid_pend got=%0b want=0", prefix_pending); errors++; end
    step();
    rst = 1'b0;
    drive(1'b1, 3'b010, 11'h0CD);
    step();
    checks++; if (immediate !== 16'hFFCD || out_valid !== 1'b1) begin
      $display("FAIL rstmid_first got imm=%h valid=%0b want imm=ffcd valid=1",
               immediate, out_valid); errors++; end
    drive(1'b0, 3'b000, 11'h000);
    step();
  endtask

  initial begin
    test_reset();
    test_extension();
    test_prefix();
    test_prefix_discard();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
